// File: rtl/nonce_dispatch_collector.sv
// nonce_dispatch_collector
//   Hands out one shared nonce per cycle to NUM_CORES hashing cores over an
//   inclusive [start, end] range (wrapping through the top of the nonce
//   space), checks every finished hash against a leading-zero difficulty and
//   queues qualifying hits for the UART side through per-core hold registers,
//   a round-robin arbiter and a first-word-fall-through FIFO.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_job_valid           pulse: load job (start/end/zero_bits), flush results
//   i_job_start/i_job_end first / last (inclusive) nonce of the range
//   i_zero_bits           required leading zero bits (clamped to CHECK_W)
//   i_core_accepted       core i consumed the offered nonce this cycle
//   i_core_done           core i result valid this cycle
//   i_core_hash           top CHECK_W hash bits, core i at [i*CHECK_W +: CHECK_W]
//   i_core_nonce          nonce of core i result, core i at [i*NONCE_W +: NONCE_W]
//   o_nonce               nonce offered to all cores
//   o_running             high while cores may accept
//   o_exhausted           last nonce of the range was consumed
//   o_res_valid/nonce/core FIFO head (first-word-fall-through)
//   i_res_ready           pop head when o_res_valid & i_res_ready
//   o_overflow            sticky: a hit was dropped
//   o_multi_accept        sticky: more than one core accepted in one cycle
//   o_hit_count           hits captured this job, saturating
module nonce_dispatch_collector #(
  parameter int NUM_CORES  = 4,
  parameter int NONCE_W    = 32,
  parameter int CHECK_W    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_job_valid,
  input  logic [NONCE_W-1:0]             i_job_start,
  input  logic [NONCE_W-1:0]             i_job_end,
  input  logic [5:0]                     i_zero_bits,
  input  logic [NUM_CORES-1:0]           i_core_accepted,
  input  logic [NUM_CORES-1:0]           i_core_done,
  input  logic [NUM_CORES*CHECK_W-1:0]   i_core_hash,
  input  logic [NUM_CORES*NONCE_W-1:0]   i_core_nonce,
  output logic [NONCE_W-1:0]             o_nonce,
  output logic                           o_running,
  output logic                           o_exhausted,
  output logic                           o_res_valid,
  output logic [NONCE_W-1:0]             o_res_nonce,
  output logic [3:0]                     o_res_core,
  input  logic                           i_res_ready,
  output logic                           o_overflow,
  output logic                           o_multi_accept,
  output logic [15:0]                    o_hit_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Difficulty requests beyond the available hash bits mean "all bits zero".
  function automatic logic [6:0] clamp_zero_bits(input logic [5:0] zb);
    logic [6:0] v;
    v = {1'b0, zb};
    if (int'(v) > CHECK_W) begin
      return 7'(CHECK_W);
    end else begin
      return v;
    end
  endfunction

  // True when the top 'need' bits of h are zero; need==0 shifts everything out.
  function automatic logic meets_difficulty(input logic [CHECK_W-1:0] h,
                                            input logic [6:0]         need);
    int sh;
    sh = CHECK_W - int'(need);
    return ((h >> sh) == {CHECK_W{1'b0}});
  endfunction

  function automatic logic [4:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Control / dispatch state
  state_t               r_state;
  state_t               w_state_next;
  logic [NONCE_W-1:0]   r_nonce;
  logic [NONCE_W-1:0]   r_job_end;
  logic [6:0]           r_zero_bits;
  logic                 r_running;
  logic                 r_exhausted;
  logic                 r_multi_accept;

  // Result collection
  logic [NUM_CORES-1:0] r_hold_valid;
  logic [NONCE_W-1:0]   r_hold_nonce [NUM_CORES];
  logic [PW-1:0]        r_rr_ptr;
  logic                 r_overflow;
  logic [15:0]          r_hit_count;

  logic [NONCE_W-1:0]   r_fifo_nonce [FIFO_DEPTH];
  logic [3:0]           r_fifo_core  [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  logic                 w_accept;
  logic                 w_multi;
  logic [NUM_CORES-1:0] w_hit;
  logic [NUM_CORES-1:0] w_load;
  logic                 w_drop;
  logic [16:0]          w_hit_sum;
  logic [15:0]          w_hit_count_next;
  logic                 w_grant_valid;
  int                   w_grant_idx;
  int                   w_scan_idx;
  logic [NONCE_W-1:0]   w_grant_nonce;
  logic [3:0]           w_grant_core;
  logic [PW-1:0]        w_ptr_next;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;

  assign w_accept = (|i_core_accepted) && (r_state == ST_RUN);
  assign w_multi  = (popcount(i_core_accepted) > 5'd1);

  // Hit qualification and hold-register availability per core
  always_comb begin
    w_hit  = {NUM_CORES{1'b0}};
    w_load = {NUM_CORES{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      w_hit[i]  = i_core_done[i] &&
                  meets_difficulty(i_core_hash[i*CHECK_W +: CHECK_W], r_zero_bits);
      w_load[i] = w_hit[i] && !r_hold_valid[i];
    end
    w_drop           = |(w_hit & r_hold_valid);
    w_hit_sum        = {1'b0, r_hit_count} + {12'd0, popcount(w_load)};
    w_hit_count_next = w_hit_sum[16] ? 16'hFFFF : w_hit_sum[15:0];
  end

  // Round-robin scan of hold registers starting at the pointer
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = 0;
    w_scan_idx    = 0;
    for (int j = 0; j < NUM_CORES; j++) begin
      w_scan_idx = (int'(r_rr_ptr) + j) % NUM_CORES;
      if (!w_grant_valid && r_hold_valid[w_scan_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_scan_idx;
      end else begin
        w_grant_valid = w_grant_valid;
      end
    end
    w_grant_nonce = r_hold_nonce[w_grant_idx];
    w_grant_core  = 4'(w_grant_idx);
    if (w_grant_idx == NUM_CORES - 1) begin
      w_ptr_next = {PW{1'b0}};
    end else begin
      w_ptr_next = PW'(w_grant_idx + 1);
    end
  end

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_count != {(AW+1){1'b0}}) && i_res_ready;
  assign w_push = w_grant_valid && (!w_full || w_pop);

  // FSM next state; a job load overrides every other transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = ST_IDLE;
      ST_RUN: begin
        if (w_accept && (r_nonce == r_job_end)) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
    if (i_job_valid) begin
      w_state_next = ST_RUN;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // FSM state register and nonce dispatch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_nonce        <= {NONCE_W{1'b0}};
      r_job_end      <= {NONCE_W{1'b0}};
      r_zero_bits    <= 7'd0;
      r_running      <= 1'b0;
      r_exhausted    <= 1'b0;
      r_multi_accept <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
      if (i_job_valid) begin
        r_nonce        <= i_job_start;
        r_job_end      <= i_job_end;
        r_zero_bits    <= clamp_zero_bits(i_zero_bits);
        r_exhausted    <= 1'b0;
        r_multi_accept <= 1'b0;
      end else if (w_accept) begin
        // The last nonce is held so cores never see one outside the range.
        if (r_nonce == r_job_end) begin
          r_exhausted <= 1'b1;
        end else begin
          r_nonce <= r_nonce + {{(NONCE_W-1){1'b0}}, 1'b1};
        end
        if (w_multi) begin
          r_multi_accept <= 1'b1;
        end
      end
    end
  end

  // Hold registers, arbiter pointer, hit counter and overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_valid <= {NUM_CORES{1'b0}};
      for (int i = 0; i < NUM_CORES; i++) begin
        r_hold_nonce[i] <= {NONCE_W{1'b0}};
      end
      r_rr_ptr    <= {PW{1'b0}};
      r_overflow  <= 1'b0;
      r_hit_count <= 16'd0;
    end else if (i_job_valid) begin
      // Flush wins over any hit arriving in the same cycle.
      r_hold_valid <= {NUM_CORES{1'b0}};
      r_rr_ptr     <= {PW{1'b0}};
      r_overflow   <= 1'b0;
      r_hit_count  <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_load[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_nonce[i] <= i_core_nonce[i*NONCE_W +: NONCE_W];
        end else if (w_push && (w_grant_idx == i)) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_rr_ptr <= w_ptr_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_hit_count <= w_hit_count_next;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else if (i_job_valid) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_nonce[i] <= {NONCE_W{1'b0}};
        r_fifo_core[i]  <= 4'd0;
      end
    end else if (w_push && !i_job_valid) begin
      r_fifo_nonce[r_wr_ptr] <= w_grant_nonce;
      r_fifo_core[r_wr_ptr]  <= w_grant_core;
    end
  end

  assign o_nonce        = r_nonce;
  assign o_running      = r_running;
  assign o_exhausted    = r_exhausted;
  assign o_res_valid    = (r_count != {(AW+1){1'b0}});
  assign o_res_nonce    = r_fifo_nonce[r_rd_ptr];
  assign o_res_core     = r_fifo_core[r_rd_ptr];
  assign o_overflow     = r_overflow;
  assign o_multi_accept = r_multi_accept;
  assign o_hit_count    = r_hit_count;

endmodule

// File: tb/tb_nonce_dispatch_collector.sv
// Directed bench for nonce_dispatch_collector (default parameters).
module tb_nonce_dispatch_collector;

  localparam int NC = 4;
  localparam int NW = 32;
  localparam int CW = 32;

  logic            clk;
  logic            rst;
  logic            job_valid;
  logic [NW-1:0]   job_start;
  logic [NW-1:0]   job_end;
  logic [5:0]      zero_bits;
  logic [NC-1:0]   core_accepted;
  logic [NC-1:0]   core_done;
  logic [NC*CW-1:0] core_hash;
  logic [NC*NW-1:0] core_nonce;
  logic [NW-1:0]   nonce;
  logic            running;
  logic            exhausted;
  logic            res_valid;
  logic [NW-1:0]   res_nonce;
  logic [3:0]      res_core;
  logic            res_ready;
  logic            overflow;
  logic            multi_accept;
  logic [15:0]     hit_count;

  int n_cmp = 0;
  int n_bad = 0;

  nonce_dispatch_collector #(
    .NUM_CORES(NC), .NONCE_W(NW), .CHECK_W(CW), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_job_valid(job_valid),
    .i_job_start(job_start), .i_job_end(job_end), .i_zero_bits(zero_bits),
    .i_core_accepted(core_accepted), .i_core_done(core_done),
    .i_core_hash(core_hash), .i_core_nonce(core_nonce),
    .o_nonce(nonce), .o_running(running), .o_exhausted(exhausted),
    .o_res_valid(res_valid), .o_res_nonce(res_nonce), .o_res_core(res_core),
    .i_res_ready(res_ready), .o_overflow(overflow),
    .o_multi_accept(multi_accept), .o_hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic load_job(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [5:0] zb);
    job_valid = 1'b1;
    job_start = s;
    job_end   = e;
    zero_bits = zb;
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0; job_start = '0; job_end = '0; zero_bits = 6'd0;
    core_accepted = '0; core_done = '0; core_hash = '0; core_nonce = '0;
    res_ready = 1'b0;
    tick(); tick();
    chk("rst_nonce", nonce, 32'h0);
    chk("rst_running", running, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_multi", multi_accept, 1'b0);
    chk("rst_hits", hit_count, 16'h0);
    rst = 1'b0;
    tick();
    chk("idle_running", running, 1'b0);

    // T1: 0x10..0x13, core0 accepts every cycle
    load_job(32'h10, 32'h13, 6'd0);
    chk("t1_load_nonce", nonce, 32'h10);
    chk("t1_running", running, 1'b1);
    core_accepted = 4'b0001;
    tick(); chk("t1_n11", nonce, 32'h11);
    tick(); chk("t1_n12", nonce, 32'h12);
    tick(); chk("t1_n13", nonce, 32'h13);
    chk("t1_not_exh", exhausted, 1'b0);
    tick();
    chk("t1_exh", exhausted, 1'b1);
    chk("t1_stop", running, 1'b0);
    chk("t1_hold", nonce, 32'h13);
    tick();
    chk("t1_hold2", nonce, 32'h13);
    core_accepted = 4'b0000;

    // T2: wrap FFFFFFFE..1, first accept from two cores at once
    load_job(32'hFFFF_FFFE, 32'h1, 6'd0);
    chk("t2_load", nonce, 32'hFFFF_FFFE);
    chk("t2_exh_clr", exhausted, 1'b0);
    core_accepted = 4'b0011;
    tick();
    chk("t2_nFF", nonce, 32'hFFFF_FFFF);
    chk("t2_multi", multi_accept, 1'b1);
    core_accepted = 4'b0001;
    tick(); chk("t2_n0", nonce, 32'h0);
    tick(); chk("t2_n1", nonce, 32'h1);
    tick();
    chk("t2_exh", exhausted, 1'b1);
    chk("t2_hold", nonce, 32'h1);
    core_accepted = 4'b0000;

    // T3: zero_bits=8, one hit and one miss
    load_job(32'h0, 32'hFFFF, 6'd8);
    chk("t3_multi_clr", multi_accept, 1'b0);
    core_done = 4'b0011;
    core_hash[0*CW +: CW]  = 32'h00FF_1234;
    core_hash[1*CW +: CW]  = 32'h0123_4567;
    core_nonce[0*NW +: NW] = 32'hAAAA_0000;
    core_nonce[1*NW +: NW] = 32'hBBBB_0000;
    tick();
    core_done = 4'b0000;
    chk("t3_hits", hit_count, 16'd1);
    chk("t3_lat1", res_valid, 1'b0);
    tick();
    chk("t3_valid", res_valid, 1'b1);
    chk("t3_nonce", res_nonce, 32'hAAAA_0000);
    chk("t3_core", res_core, 4'd0);
    res_ready = 1'b1;
    tick();
    chk("t3_popped", res_valid, 1'b0);
    chk("t3_hits2", hit_count, 16'd1);
    res_ready = 1'b0;

    // T4: all cores hit together, drained in order 0..3
    load_job(32'h0, 32'hFFFF, 6'd0);
    core_hash = '0;
    for (int i = 0; i < NC; i++) core_nonce[i*NW +: NW] = 32'h100 + i;
    core_done = 4'b1111;
    res_ready = 1'b1;
    tick();
    core_done = 4'b0000;
    chk("t4_hits", hit_count, 16'd4);
    chk("t4_lat1", res_valid, 1'b0);
    for (int i = 0; i < NC; i++) begin
      tick();
      chk("t4_valid", res_valid, 1'b1);
      chk("t4_core", res_core, 64'(i));
      chk("t4_nonce", res_nonce, 64'(32'h100 + i));
    end
    tick();
    chk("t4_empty", res_valid, 1'b0);
    chk("t4_ovf", overflow, 1'b0);
    res_ready = 1'b0;

    // T5: fill FIFO (8) and holds (4), then one more core0 hit is dropped
    load_job(32'h0, 32'hFFFF, 6'd0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NC; i++) core_nonce[i*NW +: NW] = 32'h200 + 32'h100 * p + i;
      core_done = 4'b1111;
      tick();
      core_done = 4'b0000;
      repeat (5) tick();
    end
    chk("t5_hits12", hit_count, 16'd12);
    chk("t5_no_ovf", overflow, 1'b0);
    chk("t5_head_nonce", res_nonce, 32'h200);
    chk("t5_head_core", res_core, 4'd0);
    core_nonce[0*NW +: NW] = 32'h999;
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    chk("t5_ovf", overflow, 1'b1);
    chk("t5_hits_hold", hit_count, 16'd12);

    // T6: job load mid-run with full FIFO and coincident hits
    core_done = 4'b1111;
    load_job(32'h500, 32'h5FF, 6'd0);
    core_done = 4'b0000;
    chk("t6_flush", res_valid, 1'b0);
    chk("t6_nonce", nonce, 32'h500);
    chk("t6_ovf_clr", overflow, 1'b0);
    chk("t6_hits_clr", hit_count, 16'd0);
    tick(); tick();
    chk("t6_discard", res_valid, 1'b0);
    chk("t6_discard_cnt", hit_count, 16'd0);
    core_accepted = 4'b0001;
    tick(); tick();
    chk("t6_adv", nonce, 32'h502);
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    tick();
    chk("t6_pre_rst_valid", res_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_nonce", nonce, 32'h0);
    chk("t6_rst_running", running, 1'b0);
    chk("t6_rst_valid", res_valid, 1'b0);
    chk("t6_rst_hits", hit_count, 16'd0);
    chk("t6_rst_exh", exhausted, 1'b0);
    core_accepted = 4'b0000;
    tick();
    rst = 1'b0;

    // Clamp: zero_bits=40 behaves as 32 -> only an all-zero hash qualifies
    load_job(32'h0, 32'h10, 6'd40);
    core_hash[2*CW +: CW]  = 32'h0;
    core_hash[3*CW +: CW]  = 32'h1;
    core_nonce[2*NW +: NW] = 32'h702;
    core_nonce[3*NW +: NW] = 32'h703;
    core_done = 4'b1100;
    tick();
    core_done = 4'b0000;
    chk("clamp_hits", hit_count, 16'd1);
    tick();
    chk("clamp_core", res_core, 4'd2);
    chk("clamp_nonce", res_nonce, 32'h702);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
